// File: rtl/ff_conv_pkg.sv
// ============================================================================
// ff_conv_pkg : mode encodings and FSM state type for the flop-conversion core
// Rev 1.0
// ============================================================================
`default_nettype none

package ff_conv_pkg;

   localparam logic [1:0] MODE_D  = 2'b00;
   localparam logic [1:0] MODE_SR = 2'b01;
   localparam logic [1:0] MODE_JK = 2'b10;
   localparam logic [1:0] MODE_T  = 2'b11;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_LOCKED = 1'b1
   } ff_state_t;

endpackage

`default_nettype wire

// File: rtl/exc_to_d.sv
// ============================================================================
// exc_to_d : one-bit excitation (D/SR/JK/T) to D next-state converter
// Rev 1.0
// ============================================================================
`default_nettype none

module exc_to_d
   import ff_conv_pkg::*;
(
   input  logic [1:0] mode,
   input  logic       a,
   input  logic       b,
   input  logic       q,
   output logic       d_next,
   output logic       bad
);

   always_comb begin
      d_next = q;
      bad    = 1'b0;
      case (mode)
         MODE_D:  d_next = a;
         MODE_SR: begin
            // S=R=1 holds the bit so the register never goes unknown
            case ({a, b})
               2'b01:   d_next = 1'b0;
               2'b10:   d_next = 1'b1;
               default: d_next = q;
            endcase
            bad = a & b;
         end
         MODE_JK: begin
            case ({a, b})
               2'b01:   d_next = 1'b0;
               2'b10:   d_next = 1'b1;
               2'b11:   d_next = ~q;
               default: d_next = q;
            endcase
         end
         default: d_next = a ? ~q : q;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/sr_jk_t_using_d.sv
// ============================================================================
// sr_jk_t_using_d : D-flop register bank driven by D/SR/JK/T excitation, with
// illegal-SR detection and saturating counters. FF_LOCK_ON_ERR_EN adds LOCKED.
// Rev 1.0
// ============================================================================
`default_nettype none

module sr_jk_t_using_d
   import ff_conv_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             illegal,
   output logic             err_sticky,
   output logic [CNT_W-1:0] viol_cnt,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic [WIDTH-1:0] r_q;
   logic             r_illegal;
   logic             r_err;
   logic [CNT_W-1:0] r_viol;
   logic [CNT_W-1:0] r_chg;
   ff_state_t        r_state;

   logic [WIDTH-1:0] w_d_next;
   logic [WIDTH-1:0] w_bad;
   logic             w_upd;
   logic             w_illegal;
   logic             w_changed;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         exc_to_d u_exc (
            .mode   (mode),
            .a      (a[i]),
            .b      (b[i]),
            .q      (r_q[i]),
            .d_next (w_d_next[i]),
            .bad    (w_bad[i])
         );
      end
   endgenerate

   assign w_upd     = en && (r_state == ST_RUN);
   assign w_illegal = w_upd && (|w_bad);
   assign w_changed = w_upd && (w_d_next != r_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q       <= '0;
         r_illegal <= 1'b0;
         r_err     <= 1'b0;
         r_viol    <= '0;
         r_chg     <= '0;
         r_state   <= ST_RUN;
      end else begin
         r_illegal <= w_illegal;

         if (w_upd) begin
            r_q <= w_d_next;
         end

         if (w_changed && (r_chg != c_cnt_max)) begin
            r_chg <= r_chg + c_cnt_one;
         end

         // A concurrent illegal event beats err_clr: the count restarts at one
         if (w_illegal) begin
            r_err <= 1'b1;
            if (err_clr) begin
               r_viol <= c_cnt_one;
            end else if (r_viol != c_cnt_max) begin
               r_viol <= r_viol + c_cnt_one;
            end
         end else if (err_clr) begin
            r_err  <= 1'b0;
            r_viol <= '0;
         end

`ifdef FF_LOCK_ON_ERR_EN
         case (r_state)
            ST_RUN:    if (w_illegal) r_state <= ST_LOCKED;
            ST_LOCKED: if (err_clr)   r_state <= ST_RUN;
            default:   r_state <= ST_RUN;
         endcase
`else
         r_state <= ST_RUN;
`endif
      end
   end

   assign q          = r_q;
   assign qbar       = ~r_q;
   assign illegal    = r_illegal;
   assign err_sticky = r_err;
   assign viol_cnt   = r_viol;
   assign chg_cnt    = r_chg;

endmodule

`default_nettype wire

// File: tb/tb_sr_jk_t_using_d.sv
// ============================================================================
// tb_sr_jk_t_using_d : directed self-checking bench for sr_jk_t_using_d
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sr_jk_t_using_d;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] a = 4'b0000;
   logic [3:0] b = 4'b0000;
   logic       err_clr = 1'b0;

   logic [3:0] q, qbar;
   logic       illegal, err_sticky;
   logic [7:0] viol_cnt, chg_cnt;

   logic [3:0] s_q, s_qbar;
   logic       s_illegal, s_err_sticky;
   logic [1:0] s_viol_cnt, s_chg_cnt;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   sr_jk_t_using_d #(.WIDTH(4), .CNT_W(8)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .a          (a),
      .b          (b),
      .err_clr    (err_clr),
      .q          (q),
      .qbar       (qbar),
      .illegal    (illegal),
      .err_sticky (err_sticky),
      .viol_cnt   (viol_cnt),
      .chg_cnt    (chg_cnt)
   );

   sr_jk_t_using_d #(.WIDTH(4), .CNT_W(2)) u_sat (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .a          (a),
      .b          (b),
      .err_clr    (err_clr),
      .q          (s_q),
      .qbar       (s_qbar),
      .illegal    (s_illegal),
      .err_sticky (s_err_sticky),
      .viol_cnt   (s_viol_cnt),
      .chg_cnt    (s_chg_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step(input logic e, input logic [1:0] m, input logic [3:0] va,
                       input logic [3:0] vb, input logic clr);
      en = e; mode = m; a = va; b = vb; err_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b0;
      #1 reset = 1'b1;
   endtask

   initial begin
      // power-on reset, checked before any clock edge
      #2;
      chk("rst_q", q, 4'b0000);
      chk("rst_qbar", qbar, 4'b1111);
      chk("rst_illegal", illegal, 1'b0);
      chk("rst_err", err_sticky, 1'b0);
      chk("rst_viol", viol_cnt, 8'd0);
      chk("rst_chg", chg_cnt, 8'd0);
      reset = 1'b1;

      step(1'b1, 2'b00, 4'b0110, 4'b0000, 1'b0);
      chk("d_q", q, 4'b0110);
      chk("d_qbar", qbar, 4'b1001);
      step(1'b1, 2'b01, 4'b1000, 4'b0010, 1'b0);
      chk("sr_q", q, 4'b1100);
      chk("sr_chg", chg_cnt, 8'd2);
      chk("sr_illegal", illegal, 1'b0);

      // asynchronous reset while clk is low and q is non-zero
      step(1'b1, 2'b00, 4'b1010, 4'b0000, 1'b0);
      chk("mid_q_pre", q, 4'b1010);
      chk("mid_chg_pre", chg_cnt, 8'd3);
      #2 reset = 1'b0;
      #1;
      chk("async_q", q, 4'b0000);
      chk("async_qbar", qbar, 4'b1111);
      chk("async_chg", chg_cnt, 8'd0);
      chk("async_viol", viol_cnt, 8'd0);
      #1 reset = 1'b1;

      step(1'b1, 2'b00, 4'b0001, 4'b0000, 1'b0);
      chk("d2_q", q, 4'b0001);
      step(1'b1, 2'b01, 4'b0001, 4'b0001, 1'b0);
      chk("ill_q", q, 4'b0001);
      chk("ill_pulse", illegal, 1'b1);
      chk("ill_err", err_sticky, 1'b1);
      chk("ill_viol", viol_cnt, 8'd1);
      chk("ill_chg", chg_cnt, 8'd1);
      step(1'b0, 2'b01, 4'b0001, 4'b0001, 1'b0);
      chk("ill_pulse_end", illegal, 1'b0);
      chk("ill_err_held", err_sticky, 1'b1);
      step(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b1);
      chk("clr_err", err_sticky, 1'b0);
      chk("clr_viol", viol_cnt, 8'd0);
      chk("clr_q", q, 4'b0001);

      step(1'b1, 2'b00, 4'b0101, 4'b0000, 1'b0);
      chk("d3_q", q, 4'b0101);
      step(1'b1, 2'b10, 4'b1111, 4'b1111, 1'b0);
      chk("jk_tog_q", q, 4'b1010);
      chk("jk_illegal", illegal, 1'b0);
      step(1'b1, 2'b11, 4'b0011, 4'b1100, 1'b0);
      chk("t_q", q, 4'b1001);
      chk("t_chg", chg_cnt, 8'd4);
      step(1'b0, 2'b11, 4'b1111, 4'b0000, 1'b0);
      step(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
      step(1'b0, 2'b10, 4'b1010, 4'b0101, 1'b0);
      chk("hold_q", q, 4'b1001);
      chk("hold_chg", chg_cnt, 8'd4);

      // mixed SR cycle: bit0 illegal, bit3 set, bit1 reset
      step(1'b1, 2'b01, 4'b1001, 4'b0011, 1'b0);
      chk("mix_q", q, 4'b1001);
      chk("mix_illegal", illegal, 1'b1);
      step(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b1);
      chk("mix_clr", err_sticky, 1'b0);

`ifndef FF_LOCK_ON_ERR_EN
      pulse_reset();
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 2'b01, 4'b0001, 4'b0001, 1'b0);
         chk("sat_viol", s_viol_cnt, (i > 3) ? 2'd3 : 2'(i));
         chk("sat_ill", s_illegal, 1'b1);
      end
      chk("wide_viol", viol_cnt, 8'd5);
      step(1'b1, 2'b01, 4'b0001, 4'b0001, 1'b1);
      chk("setwin_viol", s_viol_cnt, 2'd1);
      chk("setwin_err", s_err_sticky, 1'b1);
      chk("setwin_wide", viol_cnt, 8'd1);
      chk("sat_chg", s_chg_cnt, 2'd0);
`else
      pulse_reset();
      step(1'b1, 2'b01, 4'b0001, 4'b0001, 1'b0);
      chk("lock_ill", illegal, 1'b1);
      step(1'b1, 2'b00, 4'b1111, 4'b0000, 1'b0);
      chk("lock_q", q, 4'b0000);
      chk("lock_chg", chg_cnt, 8'd0);
      chk("lock_viol", viol_cnt, 8'd1);
      step(1'b1, 2'b00, 4'b1111, 4'b0000, 1'b1);
      chk("unlock_q", q, 4'b0000);
      chk("unlock_err", err_sticky, 1'b0);
      step(1'b1, 2'b00, 4'b1111, 4'b0000, 1'b0);
      chk("resume_q", q, 4'b1111);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
